// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_ctrl_pkg : shared ALU opcode encodings, FSM state encodings and the    |
// |                default multi-cycle opcode for the ALU control sequencer.   |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
package alu_ctrl_pkg;

    localparam int unsigned c_aluop_add = 1;
    localparam int unsigned c_aluop_sub = 2;
    localparam int unsigned c_aluop_and = 3;
    localparam int unsigned c_aluop_or  = 4;
    localparam int unsigned c_aluop_xor = 5;
    localparam int unsigned c_aluop_mul = 6;

    localparam int unsigned c_mc_opcode_default = c_aluop_mul;

    localparam int unsigned c_state_w = 2;
    localparam logic [c_state_w-1:0] c_st_idle = 2'd0;
    localparam logic [c_state_w-1:0] c_st_out  = 2'd1;
    localparam logic [c_state_w-1:0] c_st_mc   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_ctrl_decode : combinational priority decode of ops/func into aluop.    |
// |                   ALU_CTRL_ILLEGAL_EN adds the illegal-func flag.          |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W  = 4,
    parameter int ALUOP_W = 3
) (
    input  logic [2:0]         ops,
    input  logic [FUNC_W-1:0]  func,
    output logic [ALUOP_W-1:0] aluop,
    output logic               load
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    output logic               illegal
`endif
);

    logic w_func_hi_nz;

    generate
        if (FUNC_W > ALUOP_W) begin : g_func_hi
`ifdef ALU_CTRL_ILLEGAL_EN
            assign w_func_hi_nz = |func[FUNC_W-1:ALUOP_W];
`else
            // Upper func bits are deliberately dropped when the flag is absent.
            logic w_unused_func_hi;
            assign w_unused_func_hi = ^func[FUNC_W-1:ALUOP_W];
            assign w_func_hi_nz     = 1'b0;
`endif
        end else begin : g_no_func_hi
            assign w_func_hi_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        aluop = '0;
        load  = 1'b1;
`ifdef ALU_CTRL_ILLEGAL_EN
        illegal = 1'b0;
`endif
        if (ops[2]) begin
            aluop = func[ALUOP_W-1:0];
`ifdef ALU_CTRL_ILLEGAL_EN
            if (w_func_hi_nz) begin
                aluop   = '0;
                illegal = 1'b1;
            end
`endif
        end else if (ops[1]) begin
            aluop = ALUOP_W'(c_aluop_add);
        end else if (ops[0]) begin
            aluop = ALUOP_W'(c_aluop_sub);
        end else begin
            load = 1'b0;
        end
    end

`ifndef ALU_CTRL_ILLEGAL_EN
    logic w_unused_hi_nz;
    assign w_unused_hi_nz = w_func_hi_nz;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_ctrl_seq : ALU control sequencer; registers decoded aluop, handshakes  |
// |                it out and tracks multi-cycle ops. Option: ALU_CTRL_ILLEGAL_EN|
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int FUNC_W    = 4,
    parameter int ALUOP_W   = 3,
    parameter int MC_OPCODE = int'(c_mc_opcode_default),
    parameter int MC_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         ops,
    input  logic [FUNC_W-1:0]  func,
    output logic [ALUOP_W-1:0] aluop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    output logic               illegal
`endif
);

    localparam int c_cnt_w = (MC_CYCLES > 0) ? $clog2(MC_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load =
        (MC_CYCLES > 0) ? c_cnt_w'(MC_CYCLES - 1) : '0;

    logic [c_state_w-1:0] r_state;
    logic [ALUOP_W-1:0]   r_aluop;
    logic                 r_out_valid;
    logic                 r_busy;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [ALUOP_W-1:0]   w_dec_aluop;
    logic                 w_dec_load;
    logic                 w_mc_hit;

`ifdef ALU_CTRL_ILLEGAL_EN
    logic r_illegal;
    logic w_dec_illegal;
`endif

    alu_ctrl_decode #(
        .FUNC_W  (FUNC_W),
        .ALUOP_W (ALUOP_W)
    ) u_decode (
        .ops     (ops),
        .func    (func),
        .aluop   (w_dec_aluop),
        .load    (w_dec_load)
`ifdef ALU_CTRL_ILLEGAL_EN
        ,
        .illegal (w_dec_illegal)
`endif
    );

`ifdef ALU_CTRL_ILLEGAL_EN
    assign w_mc_hit = (MC_CYCLES > 0) && (r_aluop == ALUOP_W'(MC_OPCODE)) && !r_illegal;
    assign illegal  = r_illegal;
`else
    assign w_mc_hit = (MC_CYCLES > 0) && (r_aluop == ALUOP_W'(MC_OPCODE));
`endif

    assign in_ready  = rst_n && (r_state == c_st_idle);
    assign aluop     = r_aluop;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_aluop     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
`ifdef ALU_CTRL_ILLEGAL_EN
            r_illegal   <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    if (in_valid) begin
                        // ops == 0 still completes a transaction but reuses the old aluop.
                        if (w_dec_load) begin
                            r_aluop <= w_dec_aluop;
                        end
`ifdef ALU_CTRL_ILLEGAL_EN
                        r_illegal <= w_dec_illegal;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= c_st_out;
                    end
                end
                c_st_out: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_EN
                        r_illegal   <= 1'b0;
`endif
                        if (w_mc_hit) begin
                            r_busy  <= 1'b1;
                            r_cnt   <= c_cnt_load;
                            r_state <= c_st_mc;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end
                end
                c_st_mc: begin
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
